// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the scanned register-file scheduler.
// Pure declarations: no latency, no flow control.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int DEPTH_DEF = 7;
  localparam int WIDTH_DEF = 8;

  // Accumulator width that cannot overflow when summing depth entries of width bits.
  function automatic int sum_width(input int depth, input int width);
    return width + $clog2(depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant in the request cycle.
// Requests are held off (no grant) while en is low; pointer moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr=1 means requester 1 wins a tie; reset favours requester 0.
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/regfile_scan_sched.sv
// Register file with two RR-arbitrated writers and a sequential sum scan (done DEPTH+1 cycles after start).
// Writers stall without grant while a scan is busy or clear is high; start is ignored unless idle.
module regfile_scan_sched
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int SUM_W = sum_width(DEPTH, WIDTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             wr0_req,
  input  logic [AW-1:0]    wr0_addr,
  input  logic [WIDTH-1:0] wr0_data,
  output logic             wr0_gnt,
  input  logic             wr1_req,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [WIDTH-1:0] wr1_data,
  output logic             wr1_gnt,
  output logic             wr_err,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic [AW-1:0]    count
);

  scan_state_t      state;
  logic [AW-1:0]    idx;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [1:0]       gnt;
  logic             wr_vld;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_dat;
  logic             wr_in_range;

  assign busy = (state != IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (!busy && !clear),
    .req     ({wr1_req, wr0_req}),
    .gnt     (gnt)
  );

  assign wr0_gnt     = gnt[0];
  assign wr1_gnt     = gnt[1];
  assign wr_vld      = |gnt;
  assign wr_addr     = gnt[1] ? wr1_addr : wr0_addr;
  assign wr_dat      = gnt[1] ? wr1_data : wr0_data;
  assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign acc_nxt     = acc + SUM_W'(mem[idx]);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_vld && wr_in_range) begin
        mem[wr_addr] <= wr_dat;
      end
      // Out-of-range writes are still granted so the requester does not hang.
      wr_err <= wr_vld && !wr_in_range;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !clear) begin
            state <= SCAN;
            idx   <= '0;
            acc   <= '0;
          end
        end
        SCAN: begin
          if (clear) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            idx <= idx + AW'(1);
            if (idx == AW'(DEPTH - 1)) begin
              // Result is published together with the done pulse.
              state <= DONE;
              done  <= 1'b1;
              sum   <= acc_nxt;
              count <= AW'(DEPTH);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scan_sched.sv
// Directed bench for regfile_scan_sched with a scan-result scoreboard.
module tb_regfile_scan_sched;

  localparam int DEPTH = 7;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        clear;
  logic        wr0_req, wr1_req;
  logic [2:0]  wr0_addr, wr1_addr;
  logic [7:0]  wr0_data, wr1_data;
  logic        wr0_gnt, wr1_gnt, wr_err;
  logic        start, busy, done;
  logic [10:0] sum;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [DEPTH];
  int exp_q[$];
  int last_sum = 0;

  always #5 clk = ~clk;

  regfile_scan_sched dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .clear    (clear),
    .wr0_req  (wr0_req),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr0_gnt  (wr0_gnt),
    .wr1_req  (wr1_req),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .wr1_gnt  (wr1_gnt),
    .wr_err   (wr_err),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(mdl[i]);
    return s % 2048;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
  endtask

  task automatic wr(input int port, input int addr, input int data);
    logic [31:0] a, d;
    a = addr;
    d = data;
    @(negedge clk);
    if (port == 0) begin
      wr0_req = 1'b1; wr0_addr = a[2:0]; wr0_data = d[7:0];
    end else begin
      wr1_req = 1'b1; wr1_addr = a[2:0]; wr1_data = d[7:0];
    end
    #1;
    if (port == 0) check("wr0_gnt", wr0_gnt, 1);
    else           check("wr1_gnt", wr1_gnt, 1);
    if (addr < DEPTH) mdl[addr] = d[7:0];
    @(negedge clk);
    check("wr_err", wr_err, (addr >= DEPTH));
    wr0_req = 1'b0;
    wr1_req = 1'b0;
  endtask

  // Push the model's sum at start; pop and compare when the DUT signals done.
  task automatic run_scan(input string tag);
    int cyc;
    bit got;
    int e;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model_sum());
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cyc = 1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, cyc, DEPTH + 1);
    check({tag, "_q_size"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_sum = e;
      check({tag, "_sum"}, sum, e);
      check({tag, "_count"}, count, 7);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_sum_held"}, sum, e);
    end
  endtask

  initial begin
    int cyc, e, d;
    bit got;
    int exp_g [4] = '{0, 1, 0, 1};

    reset_l = 1'b0; clear = 1'b0; start = 1'b0;
    wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
    model_clear();
    #12;
    check("rst_sum", sum, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_err", wr_err, 0);
    @(negedge clk);
    reset_l = 1'b1;

    // Fill 0x10..0x16 -> 133
    for (int i = 0; i < DEPTH; i++) wr(0, i, 8'h10 + i);
    run_scan("fill");

    // Saturation -> 0x6F9
    for (int i = 0; i < DEPTH; i++) wr(1, i, 8'hFF);
    run_scan("sat");

    // Write held off during scan, granted once idle
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model_sum());
    @(negedge clk);
    start = 1'b0;
    wr1_req = 1'b1; wr1_addr = 3'd2; wr1_data = 8'h55;
    #1;
    check("stall_gnt", wr1_gnt, 0);
    cyc = 1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      cyc++;
      if (done) begin
        got = 1;
        break;
      end
      check("stall_gnt", wr1_gnt, 0);
    end
    check("stall_done_seen", got, 1);
    check("stall_latency", cyc, DEPTH + 1);
    check("stall_gnt_in_done", wr1_gnt, 0);
    check("stall_q_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall_sum", sum, e);
    end
    @(negedge clk);
    #1;
    check("stall_gnt_after", wr1_gnt, 1);
    mdl[2] = 8'h55;
    @(negedge clk);
    wr1_req = 1'b0;
    run_scan("rescan");

    // Clear three cycles after start aborts the scan
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_sum_kept", sum, last_sum);
    d = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) d++;
    end
    check("clr_no_done", d, 0);
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("clr_start_ignored", busy, 0);
    run_scan("after_clear");

    // Out-of-range write: granted, flagged, dropped
    wr(0, 0, 8'h21);
    wr(0, 6, 8'h07);
    run_scan("pre_bad");
    wr(0, 7, 8'hAA);
    @(negedge clk);
    check("wr_err_pulse_end", wr_err, 0);
    run_scan("post_bad");

    // Reset mid-scan
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sum", sum, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_done", done, 0);
    model_clear();

    // Contention from reset: both requesters held high
    wr0_req = 1'b1; wr0_addr = 3'd0;
    wr1_req = 1'b1; wr1_addr = 3'd1;
    @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr0_data = 8'h30 + 8'(i);
      wr1_data = 8'h40 + 8'(i);
      #1;
      check("cont_gnt0", wr0_gnt, (exp_g[i] == 0));
      check("cont_gnt1", wr1_gnt, (exp_g[i] == 1));
      if (exp_g[i] == 0) mdl[0] = wr0_data;
      else               mdl[1] = wr1_data;
      @(negedge clk);
    end
    wr0_req = 1'b0;
    wr1_req = 1'b0;
    run_scan("cont");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_scan_sched.md
Name: regfile_scan_sched

Overview:
- Scheduler for a small shared register file of DEPTH entries, each WIDTH bits.
- Two write requesters share one write port through a round-robin arbiter.
- A sequential scan engine walks the entries one per cycle and accumulates their sum.
- The sum feeds downstream match/accumulate logic; scan and writes are mutually excluded.

Parameters:
- DEPTH, 7: number of register-file entries.
- WIDTH, 8: entry width in bits.
- AW, $clog2(DEPTH) (=3): address width; derived, not overridden.
- SUM_W, 11: accumulator width. Default covers WIDTH+AW, so no overflow.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_l  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all entries; highest priority.
- wr0_req  in  1  requester 0 write request.
- wr0_addr  in  AW  requester 0 entry index.
- wr0_data  in  WIDTH  requester 0 write data.
- wr0_gnt  out  1  requester 0 granted; the write commits at this edge.
- wr1_req / wr1_addr / wr1_data / wr1_gnt: same as requester 0, for requester 1.
- wr_err  out  1  one-cycle pulse: a granted write had addr >= DEPTH.
- start  in  1  scan start pulse.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse: scan complete.
- sum  out  SUM_W  scan result; held until the next accepted start.
- count  out  AW  entries scanned by the last completed scan (= DEPTH mod 2^AW, i.e. 7).

Behaviour:
- Reset (reset_l=0, async):
  - all entries, sum, count, done, busy and wr_err = 0; FSM = IDLE.
  - RR pointer favours requester 0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN: start=1 and clear=0. Scan index idx=0, accumulator=0.
  - SCAN: each cycle, acc += zero-extended entry[idx], then idx++. After entry DEPTH-1 -> DONE.
  - DONE: one cycle. done=1; sum and count load the final values. -> IDLE.
  - start while in SCAN or DONE is ignored (not queued).
  - Latency: start sampled at edge T gives done=1 in the cycle after edge T+DEPTH, so sum is valid from T+DEPTH+1.
- busy = 1 in SCAN and DONE, combinational from state.
- Arithmetic: accumulation is unsigned modulo 2^SUM_W. Wrap is silent when SUM_W is undersized.
- Arbitration (grants are combinational, same cycle as req):
  - No grant when busy=1 or clear=1; requests simply wait.
  - Exactly one requester: it is granted.
  - Both requesting: grant the one not granted last. The pointer updates only on a grant.
  - At most one gnt per cycle.
- Write: a granted write with addr < DEPTH updates the entry at the clock edge.
  - addr >= DEPTH: granted but dropped; wr_err pulses for one cycle.
- clear:
  - zeroes all entries at the edge;
  - in SCAN, aborts to IDLE with no done pulse; sum and count keep their old values;
  - start in the same cycle as clear is ignored.
- A write and a start in the same cycle while IDLE: the write commits first; the scan sees the new value.
- Reset mid-scan: immediate return to IDLE with all outputs zeroed.

Decomposition:
- Shared package regfile_pkg holds:
  - the scan_state_t enum (IDLE, SCAN, DONE);
  - the default constants DEPTH_DEF=7 and WIDTH_DEF=8;
  - the function sum_width(depth, width) = width + $clog2(depth).
- One sub-module, rr_arb2: two-way round-robin arbiter with req[1:0], en, gnt[1:0] and an internal pointer. It is reused by other shared-resource blocks.

Test Plan:
- Fill: reset, write entries 0..6 = 0x10..0x16 via wr0, then start.
  - Expect done exactly DEPTH+1 cycles after start, sum=133 (0x085), count=7.
- Saturation: all entries = 0xFF, start.
  - Expect sum=0x6F9 (1785), no overflow.
- Contention: wr0_req and wr1_req held high from reset, 4 cycles.
  - Expect gnt sequence 0,1,0,1 and the last-written data per address.
- Busy stall: request wr1 (addr 2, data 0x55) during SCAN.
  - Expect wr1_gnt=0 until the cycle after done, then granted.
  - Expect the scanned sum to exclude 0x55 and a second scan to include it.
- Clear mid-scan: assert clear 3 cycles after start.
  - Expect busy low the next cycle, no done, sum unchanged, and a subsequent scan sum=0.
- Bad address: wr0 addr=7, data 0xAA.
  - Expect wr0_gnt=1 and a wr_err pulse, with all entries unchanged (scan sum identical before and after).
